dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/dual_port_ram.sv | 80 ++++++++
 tb/tb_dual_port_ram.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// True dual-port RAM: two independent read/write ports on one shared array,
// registered read data, and detection of same-address write-write collisions.
module dual_port_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    output logic              coll,
    output logic [7:0]        coll_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic a_wr, b_wr, a_rd, b_rd, same_wr;

    always_comb begin
        a_wr    = a_en & a_we;
        b_wr    = b_en & b_we;
        a_rd    = a_en & ~a_we;
        b_rd    = b_en & ~b_we;
        same_wr = a_wr & b_wr & (a_addr == b_addr);
    end

    // NOTE: the array sits in the async reset because every word must read
    // zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: with non-blocking assignments the last one scheduled wins,
            // so port A is written after port B to take priority on a collision.
            if (b_wr) mem[b_addr] <= b_din;
            if (a_wr) mem[a_addr] <= a_din;
        end
    end

    // Reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout  <= '0;
            b_dout  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= a_rd;
            b_valid <= b_rd;
            if (a_rd) a_dout <= mem[a_addr];
            if (b_rd) b_dout <= mem[b_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= same_wr;
            if (same_wr && coll_cnt != 8'hFF) begin
                coll_cnt <= coll_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized and directed bench for dual_port_ram; expected read data is
// queued by the stimulus and consumed by a monitor that watches the valid flags.
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [7:0] a_din = '0, b_din = '0;
    logic [7:0] a_dout, b_dout, coll_cnt;
    logic       a_valid, b_valid, coll;

    dual_port_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_addr  (a_addr),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_din   (a_din),
        .a_dout  (a_dout),
        .a_valid (a_valid),
        .b_addr  (b_addr),
        .b_en    (b_en),
        .b_we    (b_we),
        .b_din   (b_din),
        .b_dout  (b_dout),
        .b_valid (b_valid),
        .coll    (coll),
        .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: plain array plus the expectations it produces.
    logic [7:0] model_mem [8];
    logic [7:0] qa[$], qb[$];
    logic       exp_a_valid = 1'b0, exp_b_valid = 1'b0, exp_coll = 1'b0;
    int         exp_cnt = 0;
    logic [7:0] last_a = '0, last_b = '0;
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        qa.delete();
        qb.delete();
        exp_a_valid = 1'b0;
        exp_b_valid = 1'b0;
        exp_coll    = 1'b0;
        exp_cnt     = 0;
        last_a      = '0;
        last_b      = '0;
    endtask

    // Apply one access pair for one clock edge and advance the model.
    task automatic do_cycle(input logic ae, input logic awe, input logic [2:0] aa, input logic [7:0] ad,
                            input logic be, input logic bwe, input logic [2:0] ba, input logic [7:0] bd);
        a_en = ae; a_we = awe; a_addr = aa; a_din = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_din = bd;
        @(posedge clk);
        exp_a_valid = ae && !awe;
        exp_b_valid = be && !bwe;
        if (exp_a_valid) qa.push_back(model_mem[aa]);
        if (exp_b_valid) qb.push_back(model_mem[ba]);
        exp_coll = ae && awe && be && bwe && (aa == ba);
        if (exp_coll && exp_cnt < 255) exp_cnt++;
        if (be && bwe) model_mem[ba] = bd;
        if (ae && awe) model_mem[aa] = ad;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("a_valid", a_valid, exp_a_valid);
            if (a_valid) begin
                if (qa.size() == 0) check("a_unexpected_read", 1, 0);
                else begin
                    last_a = qa.pop_front();
                    check("a_dout", a_dout, last_a);
                end
            end else check("a_dout_hold", a_dout, last_a);
            check("b_valid", b_valid, exp_b_valid);
            if (b_valid) begin
                if (qb.size() == 0) check("b_unexpected_read", 1, 0);
                else begin
                    last_b = qb.pop_front();
                    check("b_dout", b_dout, last_b);
                end
            end else check("b_dout_hold", b_dout, last_b);
            check("coll", coll, exp_coll);
            check("coll_cnt", coll_cnt, exp_cnt);
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;

        // Read of a reset word, then write-then-read across ports.
        do_cycle(0, 0, 0, 0, 1, 0, 5, 0);
        do_cycle(1, 1, 2, 8'h3C, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 2, 0);
        idle(1);

        // Read-first on a same-address write/read pair.
        do_cycle(1, 1, 4, 8'h11, 0, 0, 0, 0);
        do_cycle(1, 1, 4, 8'h99, 1, 0, 4, 0);
        do_cycle(1, 0, 4, 0, 1, 0, 4, 0);

        // Write-write collision: port A wins.
        do_cycle(1, 1, 7, 8'hAA, 1, 1, 7, 8'h55);
        do_cycle(0, 0, 0, 0, 1, 0, 7, 0);
        // Different-address writes both land; en=0 ignores we/din.
        do_cycle(1, 1, 0, 8'h01, 1, 1, 1, 8'h02);
        do_cycle(0, 1, 0, 8'hEE, 0, 1, 1, 8'hEE);
        do_cycle(1, 0, 1, 0, 1, 0, 0, 0);
        idle(1);

        // Random traffic over a narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
                     $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom));
        end
        idle(1);

        // Counter saturation.
        for (int i = 0; i < 300; i++) do_cycle(1, 1, 3, 8'($urandom), 1, 1, 3, 8'($urandom));
        idle(2);
        check("coll_cnt_saturated", coll_cnt, 32'd255);

        // Fill, then reset between edges with a write still being driven.
        for (int i = 0; i < 8; i++) do_cycle(1, 1, 3'(i), 8'hF0 + 8'(i), 0, 0, 0, 0);
        do_cycle(1, 0, 6, 0, 1, 0, 7, 0);
        a_en = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_din = 8'h77;
        b_en = 1'b1; b_we = 1'b1; b_addr = 3'd5; b_din = 8'h66;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_a_dout", a_dout, 0);
        check("rst_b_dout", b_dout, 0);
        check("rst_valids", {a_valid, b_valid, coll}, 0);
        check("rst_coll_cnt", coll_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) do_cycle(1, 0, 3'(i), 0, 1, 0, 3'(7 - i), 0);
        idle(2);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
